e203_exu_eai_mch: RTL and testbench

E203_EXU_EAI_MCH -- requirements
Module: e203_exu_eai_mch

---
 rtl/e203_exu_eai_mch_pkg.sv | 22 ++
 rtl/e203_exu_eai_mch_if.sv | 61 ++++++
 rtl/e203_exu_eai_mch_fifo.sv | 58 +++++
 rtl/e203_exu_eai_mch.sv | 109 ++++++++++
 tb/tb_e203_exu_eai_mch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_exu_eai_mch_pkg.sv
// Shared constants and helpers for the EAI multi-channel dispatcher.
package e203_exu_eai_mch_pkg;

  localparam int unsigned E203_XLEN       = 32;
  localparam int unsigned E203_ITAG_WIDTH = 4;

  // Custom-0..3 opcodes differ only in instr[6:5], which doubles as the channel index.
  localparam int unsigned EAI_SEL_LSB = 5;
  localparam int unsigned EAI_SEL_W   = 2;

  localparam int unsigned EAI_CH_MIN = 1;
  localparam int unsigned EAI_CH_MAX = 4;
  localparam int unsigned EAI_DP_MIN = 2;
  localparam int unsigned EAI_DP_MAX = 8;

  typedef logic [EAI_SEL_W-1:0] eai_sel_t;

  function automatic eai_sel_t eai_sel(input logic [E203_XLEN-1:0] instr);
    return instr[EAI_SEL_LSB +: EAI_SEL_W];
  endfunction

endpackage

// File: rtl/e203_exu_eai_mch_if.sv
// Dispatch, commit, writeback and per-channel accelerator signals of the EAI dispatcher.
interface e203_exu_eai_mch_if
  import e203_exu_eai_mch_pkg::*;
#(
  parameter int unsigned CH   = 2,
  parameter int unsigned ITW  = E203_ITAG_WIDTH,
  parameter int unsigned XLEN = E203_XLEN
);
  logic            eai_i_xs_off;
  logic            eai_i_valid;
  logic            eai_i_ready;
  logic [XLEN-1:0] eai_i_instr;
  logic [XLEN-1:0] eai_i_rs1;
  logic [XLEN-1:0] eai_i_rs2;
  logic [ITW-1:0]  eai_i_itag;

  logic            eai_o_valid;
  logic            eai_o_ready;
  logic            eai_o_longpipe;
  logic            eai_o_illegal;

  logic            eai_o_itag_valid;
  logic            eai_o_itag_ready;
  logic [ITW-1:0]  eai_o_itag;
  logic [1:0]      eai_o_itag_ch;

  logic [CH-1:0]   eai_req_valid;
  logic [CH-1:0]   eai_req_ready;
  logic [XLEN-1:0] eai_req_instr;
  logic [XLEN-1:0] eai_req_rs1;
  logic [XLEN-1:0] eai_req_rs2;
  logic [CH-1:0]   eai_rsp_valid;
  logic [CH-1:0]   eai_rsp_ready;
  logic [CH-1:0]   eai_busy;

  modport slave (
    input  eai_i_xs_off, eai_i_valid, eai_i_instr, eai_i_rs1, eai_i_rs2, eai_i_itag,
    output eai_i_ready,
    output eai_o_valid, eai_o_longpipe, eai_o_illegal,
    input  eai_o_ready,
    output eai_o_itag_valid, eai_o_itag, eai_o_itag_ch,
    input  eai_o_itag_ready,
    output eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2,
    input  eai_req_ready,
    input  eai_rsp_valid,
    output eai_rsp_ready, eai_busy
  );

  modport master (
    output eai_i_xs_off, eai_i_valid, eai_i_instr, eai_i_rs1, eai_i_rs2, eai_i_itag,
    input  eai_i_ready,
    input  eai_o_valid, eai_o_longpipe, eai_o_illegal,
    output eai_o_ready,
    input  eai_o_itag_valid, eai_o_itag, eai_o_itag_ch,
    output eai_o_itag_ready,
    input  eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2,
    output eai_req_ready,
    output eai_rsp_valid,
    input  eai_rsp_ready, eai_busy
  );
endinterface

// File: rtl/e203_exu_eai_mch_fifo.sv
// Generic valid/ready FIFO; with CUT_READY set, a full FIFO refuses input even while popping.
module sirv_gnrl_fifo #(
  parameter int unsigned CUT_READY = 1,
  parameter int unsigned DP        = 4,
  parameter int unsigned DW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);
  localparam int unsigned AW = $clog2(DP);

  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] mem_d [DP];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full, empty, push, pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign i_rdy = (CUT_READY != 0) ? ~full : (~full | o_rdy);
  assign o_vld = ~empty;
  assign o_dat = mem_q[rptr_q[AW-1:0]];
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = i_dat;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DP; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end
endmodule

// File: rtl/e203_exu_eai_mch.sv
// EAI multi-channel dispatcher: routes custom instructions to accelerator channels and
// returns their itags in order per channel through a round-robin writeback arbiter.
module e203_exu_eai_mch
  import e203_exu_eai_mch_pkg::*;
#(
  parameter int unsigned CH  = 2,
  parameter int unsigned DP  = 4,
  parameter int unsigned ITW = E203_ITAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  e203_exu_eai_mch_if.slave     bus
);
  eai_sel_t       sel;
  logic           legal, bypass;
  logic           sel_fifo_rdy, sel_req_ready;
  logic [CH-1:0]  req_valid, push, cand, gnt_oh;
  logic [CH-1:0]  fifo_rdy, fifo_vld;
  logic [ITW-1:0] fifo_dat [CH];
  logic [ITW-1:0] itag_mux;
  logic [1:0]     rr_q, rr_d, gnt_idx;
  logic           gnt_any, gnt_found;
  int unsigned    rr_idx;

  assign sel    = eai_sel(bus.eai_i_instr);
  assign legal  = (32'(sel) < CH);
  assign bypass = bus.eai_i_xs_off | ~legal;

  always_comb begin
    sel_fifo_rdy  = 1'b0;
    sel_req_ready = 1'b0;
    req_valid     = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (sel == 2'(c)) begin
        sel_fifo_rdy  = fifo_rdy[c];
        sel_req_ready = bus.eai_req_ready[c];
        req_valid[c]  = ~bypass & bus.eai_i_valid & bus.eai_o_ready & fifo_rdy[c];
      end
    end
  end

  assign bus.eai_req_valid  = req_valid;
  assign bus.eai_req_instr  = bus.eai_i_instr;
  assign bus.eai_req_rs1    = bus.eai_i_rs1;
  assign bus.eai_req_rs2    = bus.eai_i_rs2;
  assign bus.eai_o_valid    = bypass ? bus.eai_i_valid
                                     : (bus.eai_i_valid & sel_req_ready & sel_fifo_rdy);
  assign bus.eai_i_ready    = bypass ? bus.eai_o_ready
                                     : (bus.eai_o_ready & sel_req_ready & sel_fifo_rdy);
  assign bus.eai_o_longpipe = ~bypass;
  assign bus.eai_o_illegal  = ~legal & ~bus.eai_i_xs_off;

  assign push = req_valid & bus.eai_req_ready;
  assign cand = bus.eai_rsp_valid & fifo_vld;

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    for (int unsigned k = 1; k <= CH; k++) begin
      rr_idx = (32'(rr_q) + k) % CH;
      if (!gnt_found && cand[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(rr_idx);
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    itag_mux = fifo_dat[0];
    for (int unsigned c = 0; c < CH; c++) begin
      gnt_oh[c] = cand[c] & (gnt_idx == 2'(c));
      if (gnt_idx == 2'(c)) itag_mux = fifo_dat[c];
    end
  end

  assign gnt_any              = |cand;
  assign bus.eai_o_itag_valid = gnt_any;
  assign bus.eai_o_itag       = itag_mux;
  assign bus.eai_o_itag_ch    = gnt_idx;
  assign bus.eai_rsp_ready    = gnt_oh & {CH{bus.eai_o_itag_ready}};
  assign bus.eai_busy         = fifo_vld;

  assign rr_d = (bus.eai_o_itag_ready & gnt_any) ? gnt_idx : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 2'(CH-1);
    else        rr_q <= rr_d;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    sirv_gnrl_fifo #(
      .CUT_READY (1),
      .DP        (DP),
      .DW        (ITW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (push[c]),
      .i_rdy (fifo_rdy[c]),
      .i_dat (bus.eai_i_itag),
      .o_vld (fifo_vld[c]),
      .o_rdy (bus.eai_rsp_ready[c]),
      .o_dat (fifo_dat[c])
    );
  end
endmodule

// File: tb/tb_e203_exu_eai_mch.sv
// Directed bench for e203_exu_eai_mch with CH=2, DP=4, ITW=4.
module tb_e203_exu_eai_mch;
  localparam int unsigned CH  = 2;
  localparam int unsigned DP  = 4;
  localparam int unsigned ITW = 4;

  localparam logic [31:0] CUSTOM0 = 32'h0000_000B;
  localparam logic [31:0] CUSTOM1 = 32'h0000_002B;
  localparam logic [31:0] CUSTOM3 = 32'h0000_007B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  e203_exu_eai_mch_if #(.CH(CH), .ITW(ITW), .XLEN(32)) bus ();

  e203_exu_eai_mch #(.CH(CH), .DP(DP), .ITW(ITW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.eai_i_xs_off     = 1'b0;
    bus.eai_i_valid      = 1'b0;
    bus.eai_i_instr      = '0;
    bus.eai_i_rs1        = 32'h1111_1111;
    bus.eai_i_rs2        = 32'h2222_2222;
    bus.eai_i_itag       = '0;
    bus.eai_o_ready      = 1'b0;
    bus.eai_o_itag_ready = 1'b0;
    bus.eai_req_ready    = '0;
    bus.eai_rsp_valid    = '0;

    tick(); tick();
    chk("rst_itag_valid", 32'(bus.eai_o_itag_valid), 32'h0);
    chk("rst_rsp_ready",  32'(bus.eai_rsp_ready),    32'h0);
    chk("rst_busy",       32'(bus.eai_busy),         32'h0);
    chk("rst_req_valid",  32'(bus.eai_req_valid),    32'h0);
    rst_n = 1'b1;
    tick();

    // Single custom-1 dispatch and writeback.
    bus.eai_i_instr   = CUSTOM1;
    bus.eai_i_itag    = 4'd5;
    bus.eai_i_valid   = 1'b1;
    bus.eai_o_ready   = 1'b1;
    bus.eai_req_ready = 2'b11;
    #1;
    chk("c1_req_valid", 32'(bus.eai_req_valid),  32'h2);
    chk("c1_o_valid",   32'(bus.eai_o_valid),    32'h1);
    chk("c1_i_ready",   32'(bus.eai_i_ready),    32'h1);
    chk("c1_longpipe",  32'(bus.eai_o_longpipe), 32'h1);
    chk("c1_illegal",   32'(bus.eai_o_illegal),  32'h0);
    chk("c1_req_instr", bus.eai_req_instr,       CUSTOM1);
    chk("c1_req_rs2",   bus.eai_req_rs2,         32'h2222_2222);
    tick();
    bus.eai_i_valid = 1'b0;
    #1;
    chk("c1_busy", 32'(bus.eai_busy), 32'h2);
    bus.eai_rsp_valid    = 2'b10;
    bus.eai_o_itag_ready = 1'b1;
    #1;
    chk("c1_itag_valid", 32'(bus.eai_o_itag_valid), 32'h1);
    chk("c1_itag",       32'(bus.eai_o_itag),       32'h5);
    chk("c1_itag_ch",    32'(bus.eai_o_itag_ch),    32'h1);
    chk("c1_rsp_ready",  32'(bus.eai_rsp_ready),    32'h2);
    tick();
    bus.eai_rsp_valid = 2'b00;
    #1;
    chk("c1_busy_after_pop", 32'(bus.eai_busy), 32'h0);

    // Unimplemented channel and extension-off bypass.
    bus.eai_i_instr = CUSTOM3;
    bus.eai_i_valid = 1'b1;
    #1;
    chk("ill_o_valid",   32'(bus.eai_o_valid),    32'h1);
    chk("ill_illegal",   32'(bus.eai_o_illegal),  32'h1);
    chk("ill_longpipe",  32'(bus.eai_o_longpipe), 32'h0);
    chk("ill_req_valid", 32'(bus.eai_req_valid),  32'h0);
    chk("ill_i_ready",   32'(bus.eai_i_ready),    32'h1);
    bus.eai_o_ready = 1'b0;
    #1;
    chk("ill_i_ready_stall", 32'(bus.eai_i_ready), 32'h0);
    bus.eai_o_ready  = 1'b1;
    bus.eai_i_instr  = CUSTOM1;
    bus.eai_i_xs_off = 1'b1;
    #1;
    chk("xsoff_illegal",   32'(bus.eai_o_illegal),  32'h0);
    chk("xsoff_longpipe",  32'(bus.eai_o_longpipe), 32'h0);
    chk("xsoff_req_valid", 32'(bus.eai_req_valid),  32'h0);
    bus.eai_i_xs_off = 1'b0;
    bus.eai_i_valid  = 1'b0;
    tick();

    // Fill channel 0, then a fifth dispatch to it stalls while channel 1 proceeds.
    bus.eai_i_instr = CUSTOM0;
    bus.eai_i_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.eai_i_itag = 4'(i);
      #1;
      chk("fill_i_ready", 32'(bus.eai_i_ready), 32'h1);
      tick();
    end
    bus.eai_i_itag = 4'd6;
    #1;
    chk("full_i_ready",   32'(bus.eai_i_ready),   32'h0);
    chk("full_req_valid", 32'(bus.eai_req_valid), 32'h0);
    chk("full_o_valid",   32'(bus.eai_o_valid),   32'h0);
    bus.eai_i_instr = CUSTOM1;
    bus.eai_i_itag  = 4'd7;
    #1;
    chk("ch1_i_ready",   32'(bus.eai_i_ready),   32'h1);
    chk("ch1_req_valid", 32'(bus.eai_req_valid), 32'h2);
    tick();
    bus.eai_i_itag = 4'd8;
    #1;
    chk("ch1_i_ready2", 32'(bus.eai_i_ready), 32'h1);
    tick();
    bus.eai_i_valid = 1'b0;
    #1;
    chk("both_busy", 32'(bus.eai_busy), 32'h3);

    // Round-robin alternation (last grant was channel 1), then a 3-cycle hold.
    bus.eai_rsp_valid    = 2'b11;
    bus.eai_o_itag_ready = 1'b1;
    #1;
    chk("rr0_ch",   32'(bus.eai_o_itag_ch), 32'h0);
    chk("rr0_itag", 32'(bus.eai_o_itag),    32'h1);
    chk("rr0_rsp",  32'(bus.eai_rsp_ready), 32'h1);
    tick();
    chk("rr1_ch",   32'(bus.eai_o_itag_ch), 32'h1);
    chk("rr1_itag", 32'(bus.eai_o_itag),    32'h7);
    chk("rr1_rsp",  32'(bus.eai_rsp_ready), 32'h2);
    tick();
    chk("rr2_ch",   32'(bus.eai_o_itag_ch), 32'h0);
    chk("rr2_itag", 32'(bus.eai_o_itag),    32'h2);
    tick();
    bus.eai_o_itag_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ch",    32'(bus.eai_o_itag_ch),    32'h1);
      chk("hold_itag",  32'(bus.eai_o_itag),       32'h8);
      chk("hold_valid", 32'(bus.eai_o_itag_valid), 32'h1);
      chk("hold_rsp",   32'(bus.eai_rsp_ready),    32'h0);
      tick();
    end
    bus.eai_o_itag_ready = 1'b1;
    #1;
    chk("rr3_ch",   32'(bus.eai_o_itag_ch), 32'h1);
    chk("rr3_itag", 32'(bus.eai_o_itag),    32'h8);
    chk("rr3_rsp",  32'(bus.eai_rsp_ready), 32'h2);
    tick();
    bus.eai_rsp_valid = 2'b00;

    // Channel 0 holds {3,4}; refill to full with 9,10.
    bus.eai_i_instr = CUSTOM0;
    bus.eai_i_valid = 1'b1;
    bus.eai_i_itag  = 4'd9;
    #1;
    chk("ref_i_ready9", 32'(bus.eai_i_ready), 32'h1);
    tick();
    bus.eai_i_itag = 4'd10;
    #1;
    chk("ref_i_ready10", 32'(bus.eai_i_ready), 32'h1);
    tick();
    // Full: the pop proceeds but the push waits one cycle.
    bus.eai_i_itag    = 4'd11;
    bus.eai_rsp_valid = 2'b01;
    #1;
    chk("pp_full_i_ready", 32'(bus.eai_i_ready),   32'h0);
    chk("pp_full_rsp",     32'(bus.eai_rsp_ready), 32'h1);
    chk("pp_full_itag",    32'(bus.eai_o_itag),    32'h3);
    tick();
    chk("pp_i_ready",   32'(bus.eai_i_ready),   32'h1);
    chk("pp_req_valid", 32'(bus.eai_req_valid), 32'h1);
    chk("pp_itag",      32'(bus.eai_o_itag),    32'h4);
    chk("pp_rsp",       32'(bus.eai_rsp_ready), 32'h1);
    tick();
    bus.eai_rsp_valid = 2'b00;
    bus.eai_i_itag    = 4'd12;
    #1;
    chk("pp_i_ready12", 32'(bus.eai_i_ready), 32'h1);
    tick();
    bus.eai_i_itag = 4'd13;
    #1;
    chk("pp_refull_i_ready", 32'(bus.eai_i_ready), 32'h0);
    bus.eai_i_valid   = 1'b0;
    bus.eai_rsp_valid = 2'b01;
    for (int i = 9; i <= 12; i++) begin
      #1;
      chk("drain_itag", 32'(bus.eai_o_itag),    32'(i));
      chk("drain_ch",   32'(bus.eai_o_itag_ch), 32'h0);
      tick();
    end
    chk("empty_itag_valid", 32'(bus.eai_o_itag_valid), 32'h0);
    chk("empty_rsp_ready",  32'(bus.eai_rsp_ready),    32'h0);
    chk("empty_busy",       32'(bus.eai_busy),         32'h0);
    bus.eai_rsp_valid = 2'b00;

    // Reset with three itags outstanding.
    bus.eai_i_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.eai_i_itag = 4'(i);
      tick();
    end
    bus.eai_i_valid = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(bus.eai_busy), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(bus.eai_busy), 32'h0);
    rst_n = 1'b1;
    bus.eai_rsp_valid = 2'b11;
    #1;
    chk("post_rst_itag_valid", 32'(bus.eai_o_itag_valid), 32'h0);
    chk("post_rst_rsp_ready",  32'(bus.eai_rsp_ready),    32'h0);
    bus.eai_rsp_valid = 2'b00;
    tick();

    // After reset channel 0 wins the first arbitration.
    bus.eai_i_valid = 1'b1;
    bus.eai_i_instr = CUSTOM1;
    bus.eai_i_itag  = 4'd4;
    tick();
    bus.eai_i_instr = CUSTOM0;
    bus.eai_i_itag  = 4'd5;
    tick();
    bus.eai_i_valid   = 1'b0;
    bus.eai_rsp_valid = 2'b11;
    #1;
    chk("first_gnt_ch",   32'(bus.eai_o_itag_ch), 32'h0);
    chk("first_gnt_itag", 32'(bus.eai_o_itag),    32'h5);
    tick();
    chk("second_gnt_ch",   32'(bus.eai_o_itag_ch), 32'h1);
    chk("second_gnt_itag", 32'(bus.eai_o_itag),    32'h4);
    tick();
    bus.eai_rsp_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
